jump_motion: RTL and testbench

- Consumer side of the press-measurement interface: takes `is_pressing` / `press_time` from the button-press logic and turns a completed press into a discrete jump trajectory.
- Outputs horizontal offset and vertical height per animation step, plus a landing pulse. The VGA renderer and the score/collision logic read these.
- Advances only on `tick`, a one-cycle frame/step strobe from the display timing.

---
 rtl/jump_motion_pkg.sv | 12 +
 rtl/jump_motion_edge_detect_fall.sv | 19 +
 rtl/jump_motion.sv | 121 ++++++++++++
 tb/tb_jump_motion.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_motion_pkg.sv
// Shared types and constants for the jump trajectory generator and its helpers.
package jump_motion_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    JUMP = 1'b1
  } state_t;

  localparam int PRESS_W        = 4;
  localparam int JUMP_STEPS_DEF = 16;

endpackage

// File: rtl/jump_motion_edge_detect_fall.sv
// Falling-edge detector: registers sig each clk, fall is high for the single cycle
// in which sig has just dropped (combinational from the register, no backpressure).
module edge_detect_fall (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_q <= 1'b0;
    else      sig_q <= sig;
  end

  assign fall = sig_q & ~sig;

endmodule

// File: rtl/jump_motion.sv
// Turns a completed button press into a parabolic jump stepped on tick; outputs are registered,
// launch shows busy one cycle after the release edge. JUMP_PRESS_BUFFER_EN queues one release seen mid-jump.
module jump_motion
  import jump_motion_pkg::*;
#(
  parameter int JUMP_STEPS = JUMP_STEPS_DEF,
  parameter int X_W        = 10,
  parameter int Y_W        = 8,
  parameter int Y_SHIFT    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               is_pressing,
  input  logic [PRESS_W-1:0] press_time,
  output logic               busy,
  output logic [X_W-1:0]     x_offset,
  output logic [Y_W-1:0]     y_height,
  output logic [X_W-1:0]     land_x,
  output logic               jump_done
);

  localparam int KW   = $clog2(JUMP_STEPS + 1);
  localparam int YR_W = Y_W + Y_SHIFT + 1;

  state_t                   state;
  logic [KW-1:0]            k;
  logic [PRESS_W-1:0]       speed;
  logic signed [YR_W-1:0]   y_raw;
  logic                     fall;
  logic [X_W:0]             x_sum;
  logic [X_W-1:0]           x_next;
  logic signed [YR_W-1:0]   y_step;
  logic                     last_step;
  logic                     start_go;
  logic [PRESS_W-1:0]       start_speed;

  edge_detect_fall u_fall (
    .clk  (clk),
    .rst  (rst),
    .sig  (is_pressing),
    .fall (fall)
  );

  always_comb begin
    x_sum     = {1'b0, x_offset} + (X_W+1)'(speed);
    x_next    = x_sum[X_W] ? '1 : x_sum[X_W-1:0];
    // Parabola by first differences: sum of (N-2j-1) for j<k equals k*(N-k).
    y_step    = YR_W'(JUMP_STEPS - 1 - 2 * int'(k));
    last_step = (k == KW'(JUMP_STEPS - 1));
  end

`ifdef JUMP_PRESS_BUFFER_EN
  logic               buf_vld;
  logic [PRESS_W-1:0] buf_time;

  assign start_go    = (state == IDLE) && (buf_vld || (fall && (press_time != '0)));
  assign start_speed = buf_vld ? buf_time : press_time;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld  <= 1'b0;
      buf_time <= '0;
    end else if ((state == JUMP) && fall && (press_time != '0)) begin
      buf_vld  <= 1'b1;
      buf_time <= press_time;
    end else if (start_go) begin
      buf_vld  <= 1'b0;
    end
  end
`else
  assign start_go    = (state == IDLE) && fall && (press_time != '0);
  assign start_speed = press_time;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      speed     <= '0;
      y_raw     <= '0;
      x_offset  <= '0;
      land_x    <= '0;
      busy      <= 1'b0;
      jump_done <= 1'b0;
    end else begin
      jump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            speed    <= start_speed;
            k        <= '0;
            x_offset <= '0;
            y_raw    <= '0;
            busy     <= 1'b1;
            state    <= JUMP;
          end
        end
        JUMP: begin
          if (tick) begin
            k        <= k + KW'(1);
            x_offset <= x_next;
            if (last_step) begin
              y_raw     <= '0;
              land_x    <= x_next;
              jump_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              y_raw <= y_raw + y_step;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign y_height = Y_W'(y_raw >>> Y_SHIFT);

endmodule

// File: tb/tb_jump_motion.sv
// Directed bench for jump_motion: default-width instance plus a 6-bit x instance for saturation.
module tb_jump_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       is_pressing = 1'b0;
  logic [3:0] press_time = 4'd0;

  logic       busy, jump_done;
  logic [9:0] x_offset, land_x;
  logic [7:0] y_height;
  logic       s_busy, s_jump_done;
  logic [5:0] s_x_offset, s_land_x;
  logic [7:0] s_y_height;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  jump_motion dut (
    .clk(clk), .rst(rst), .tick(tick), .is_pressing(is_pressing), .press_time(press_time),
    .busy(busy), .x_offset(x_offset), .y_height(y_height), .land_x(land_x), .jump_done(jump_done)
  );

  jump_motion #(.X_W(6)) dut_s (
    .clk(clk), .rst(rst), .tick(tick), .is_pressing(is_pressing), .press_time(press_time),
    .busy(s_busy), .x_offset(s_x_offset), .y_height(s_y_height), .land_x(s_land_x),
    .jump_done(s_jump_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (jump_done) done_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [3:0] pt, input logic with_tick);
    is_pressing = 1'b1;
    press_time  = pt;
    repeat (3) cyc();
    is_pressing = 1'b0;
    tick        = with_tick;
    cyc();
    tick = 1'b0;
  endtask

  task automatic step();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    int busy_seen;
    rst = 1'b0;
    repeat (3) cyc();
    tests_run++;
    if ({busy, x_offset, y_height, land_x, jump_done} !== 30'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%0b x=%0d y=%0d land=%0d done=%0b, expected all 0",
               busy, x_offset, y_height, land_x, jump_done);
    end
    rst = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 24; i++) begin
      tick = (i % 4 == 0);
      cyc();
      if (busy || jump_done) busy_seen++;
    end
    tick = 1'b0;
    tests_run++;
    if (busy_seen != 0 || x_offset !== 10'd0 || y_height !== 8'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy/done cycles=%0d x=%0d y=%0d, expected 0 0 0",
               busy_seen, x_offset, y_height);
    end
  endtask

  task automatic test_jump();
    int base, peak;
    base = done_cnt;
    peak = 0;
    launch(4'd5, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || x_offset !== 10'd0 || y_height !== 8'd0) begin
      tests_failed++;
      $display("FAIL launch: busy=%0b x=%0d y=%0d, expected 1 0 0", busy, x_offset, y_height);
    end
    for (int i = 1; i <= 16; i++) begin
      step();
      tests_run++;
      if (x_offset !== 10'(5 * i) || y_height !== 8'(i * (16 - i))) begin
        tests_failed++;
        $display("FAIL step%0d: x=%0d y=%0d, expected x=%0d y=%0d",
                 i, x_offset, y_height, 5 * i, i * (16 - i));
      end
      if (int'(y_height) > peak) peak = int'(y_height);
      if (i < 16) begin
        tests_run++;
        if (busy !== 1'b1 || jump_done !== 1'b0) begin
          tests_failed++;
          $display("FAIL inflight%0d: busy=%0b done=%0b, expected 1 0", i, busy, jump_done);
        end
        repeat (3) cyc();
      end
    end
    tests_run++;
    if (busy !== 1'b0 || jump_done !== 1'b1 || land_x !== 10'd80) begin
      tests_failed++;
      $display("FAIL landing: busy=%0b done=%0b land=%0d, expected 0 1 80", busy, jump_done, land_x);
    end
    cyc();
    tests_run++;
    if (jump_done !== 1'b0 || x_offset !== 10'd80 || done_cnt - base != 1 || peak != 64) begin
      tests_failed++;
      $display("FAIL after_land: done=%0b x=%0d pulses=%0d peak=%0d, expected 0 80 1 64",
               jump_done, x_offset, done_cnt - base, peak);
    end
  endtask

  task automatic test_zero_press();
    int base;
    base = done_cnt;
    launch(4'd0, 1'b0);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_press_busy: busy=%0b, expected 0", busy);
    end
    repeat (8) begin
      step();
      repeat (3) cyc();
    end
    tests_run++;
    if (busy !== 1'b0 || done_cnt != base || land_x !== 10'd80 || x_offset !== 10'd80) begin
      tests_failed++;
      $display("FAIL zero_press_hold: busy=%0b pulses=%0d land=%0d x=%0d, expected 0 0 80 80",
               busy, done_cnt - base, land_x, x_offset);
    end
  endtask

  task automatic test_mid_jump_press();
    int base, busy_seen;
    base = done_cnt;
    launch(4'd7, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      repeat (3) cyc();
    end
    is_pressing = 1'b1;
    press_time  = 4'd3;
    repeat (2) cyc();
    is_pressing = 1'b0;
    cyc();
    tests_run++;
    if (busy !== 1'b1 || x_offset !== 10'd28) begin
      tests_failed++;
      $display("FAIL mid_press_inflight: busy=%0b x=%0d, expected 1 28", busy, x_offset);
    end
    for (int i = 5; i <= 16; i++) begin
      step();
      if (i < 16) repeat (3) cyc();
    end
    tests_run++;
    if (land_x !== 10'd112 || jump_done !== 1'b1 || done_cnt - base != 0) begin
      tests_failed++;
      $display("FAIL mid_press_land: land=%0d done=%0b, expected 112 1", land_x, jump_done);
    end
`ifdef JUMP_PRESS_BUFFER_EN
    cyc();
    tests_run++;
    if (busy !== 1'b1 || x_offset !== 10'd0) begin
      tests_failed++;
      $display("FAIL buffered_launch: busy=%0b x=%0d, expected 1 0", busy, x_offset);
    end
    for (int i = 1; i <= 16; i++) begin
      repeat (3) cyc();
      step();
    end
    tests_run++;
    if (land_x !== 10'd48 || jump_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL buffered_land: land=%0d done=%0b, expected 48 1", land_x, jump_done);
    end
    cyc();
`else
    busy_seen = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      tick = (i % 4 == 0);
      if (busy) busy_seen++;
    end
    tick = 1'b0;
    cyc();
    tests_run++;
    if (busy_seen != 0 || land_x !== 10'd112) begin
      tests_failed++;
      $display("FAIL mid_press_discard: busy cycles=%0d land=%0d, expected 0 112", busy_seen, land_x);
    end
`endif
  endtask

  task automatic test_saturation();
    int exp_s;
    launch(4'd15, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_s = (15 * i > 63) ? 63 : 15 * i;
      tests_run++;
      if (s_x_offset !== 6'(exp_s) || x_offset !== 10'(15 * i)) begin
        tests_failed++;
        $display("FAIL sat_step%0d: narrow x=%0d wide x=%0d, expected %0d %0d",
                 i, s_x_offset, x_offset, exp_s, 15 * i);
      end
      if (i < 16) repeat (3) cyc();
    end
    tests_run++;
    if (s_land_x !== 6'd63 || land_x !== 10'd240 || s_jump_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_land: narrow land=%0d wide land=%0d done=%0b, expected 63 240 1",
               s_land_x, land_x, s_jump_done);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int base;
    base = done_cnt;
    launch(4'd5, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      step();
      repeat (3) cyc();
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, x_offset, y_height, land_x, jump_done} !== 30'd0 || s_land_x !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%0b x=%0d y=%0d land=%0d done=%0b, expected all 0",
               busy, x_offset, y_height, land_x, jump_done);
    end
    repeat (2) cyc();
    rst = 1'b1;
    repeat (12) begin
      step();
      repeat (3) cyc();
    end
    tests_run++;
    if (done_cnt != base || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_nodone: pulses=%0d busy=%0b, expected 0 0", done_cnt - base, busy);
    end
    // Tick coincident with the release edge only launches.
    launch(4'd2, 1'b1);
    tests_run++;
    if (busy !== 1'b1 || x_offset !== 10'd0) begin
      tests_failed++;
      $display("FAIL launch_with_tick: busy=%0b x=%0d, expected 1 0", busy, x_offset);
    end
    repeat (3) cyc();
    step();
    tests_run++;
    if (x_offset !== 10'd2 || y_height !== 8'd15) begin
      tests_failed++;
      $display("FAIL relaunch_step1: x=%0d y=%0d, expected 2 15", x_offset, y_height);
    end
    for (int i = 2; i <= 16; i++) begin
      repeat (3) cyc();
      step();
    end
    tests_run++;
    if (land_x !== 10'd32 || jump_done !== 1'b1 || y_height !== 8'd0) begin
      tests_failed++;
      $display("FAIL relaunch_land: land=%0d done=%0b y=%0d, expected 32 1 0",
               land_x, jump_done, y_height);
    end
    cyc();
    tests_run++;
    if (done_cnt - base != 1) begin
      tests_failed++;
      $display("FAIL relaunch_pulses: pulses=%0d, expected 1", done_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_zero_press();
    test_mid_jump_press();
    test_saturation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
